program_sequencer_stack: RTL and testbench
==========================================

Name: program_sequencer_stack

Overview:
Parametrised next-generation program sequencer for the MPU341 core. It generates the program-memory address each cycle and registers it as the program counter. Beyond sequential fetch, absolute jumps and conditional jump-on-not-zero, it adds a configurable address width, a stall input and a hardware call/return stack with sticky overflow and underflow flags. It sits between the instruction decoder/ALU flags and program memory.

Parameters:
PM_ADDR_W, 8, program-memory address width in bits; also the width of pc and each stack entry.
JMP_ADDR_W, 4, jump-target field width. Absolute target = {jmp_addr, (PM_ADDR_W-JMP_ADDR_W) zeros}. Must be ≤ PM_ADDR_W.
STACK_DEPTH, 4, number of return-address entries; ≥1.

Ports:
clk  in  1  global clock
sync_reset  in  1  synchronous reset, active-high
jmp  in  1  unconditional jump
jmp_nz  in  1  conditional jump; taken when dont_jmp=0
dont_jmp  in  1  ALU zero flag; suppresses jmp_nz
call  in  1  push return address (pc+1), jump to target
ret  in  1  pop top of stack into pm_addr
hold  in  1  stall; pm_addr = pc, stack unchanged
jmp_addr  in  JMP_ADDR_W  jump/call target field
pm_addr  out  PM_ADDR_W  next fetch address (combinational)
pc  out  PM_ADDR_W  registered current program counter
stack_level  out  clog2(STACK_DEPTH+1)  number of valid stack entries
stack_ovf  out  1  sticky: call attempted while stack full
stack_unf  out  1  sticky: ret attempted while stack empty

Behaviour:
- Single clock domain; all state updates on posedge clk; reset is synchronous, active-high, on port sync_reset.
- pc <= pm_addr every rising edge. pm_addr is a combinational function of pc, the stack and the control inputs, so it takes effect at the next edge.
- pm_addr selection, highest priority first:
  - sync_reset: 0
  - hold: pc
  - ret: top of stack if stack_level>0, else pc+1
  - call: target
  - jmp: target
  - jmp_nz & !dont_jmp: target
  - otherwise: pc+1
- Increment is modulo 2^PM_ADDR_W: pc all-ones wraps to 0 on every pc+1 path.
- Stack is a LIFO of STACK_DEPTH entries:
  - call with level<STACK_DEPTH: writes pc+1 (wrapped), level+1.
  - call with level==STACK_DEPTH: jump still taken, push dropped, existing entries kept, stack_ovf<=1.
  - ret with level>0: level-1.
  - ret with level==0: no pop, stack_unf<=1.
- Stack changes happen only on the same edge that consumes pm_addr. No stack change under hold or sync_reset.
- call and ret together: ret wins, call ignored, no push.
- jmp and jmp_nz together: jmp wins (same target).
- Reset, including mid-operation:
  - pm_addr=0 combinationally while sync_reset=1.
  - At the next edge: pc=0, stack_level=0, stack_ovf=0, stack_unf=0. Stack contents need not be cleared.
- stack_ovf and stack_unf clear only on reset.
- No latency beyond one register: a control input sampled at edge N determines pc after edge N.

Optional Feature:
PS_REL_JMP_EN.
- Defined:
  - Adds input jmp_rel (1 bit).
  - When jmp_rel=1 during jmp, jmp_nz-taken or call, target = pc + sign-extended jmp_addr, modulo 2^PM_ADDR_W, instead of the absolute target.
  - call still pushes pc+1.
- Undefined: port absent; all targets absolute.

Test Plan:
- Reset then free-run, PM_ADDR_W=8: sync_reset 1 cycle, then idle -> pc = 0,1,2,…; after 0xFF, pc=0x00; flags 0, stack_level 0.
- Jumps: pc=0x05, jmp=1, jmp_addr=0x3 -> pc=0x30 next cycle. pc=0x31, jmp_nz=1, dont_jmp=1 -> pc=0x32. jmp_nz=1, dont_jmp=0, jmp_addr=0xA -> pc=0xA0.
- Call/return: pc=0x12, call, jmp_addr=0x4 -> pc=0x40, level=1. Run to 0x43, ret -> pc=0x13, level=0. Nested depth 3 calls unwind in LIFO order.
- Overflow/underflow, STACK_DEPTH=4: 5 consecutive calls -> 5th jumps, level stays 4, stack_ovf=1. 4 rets return correct addresses. 5th ret -> pc=pc+1, stack_unf=1. Both flags held until sync_reset.
- Hold and simultaneity: hold=1 with jmp=1 for 3 cycles -> pc frozen, level unchanged. call+ret same cycle with level=1 -> pops, no push, level=0.
- Reset mid-call: call asserted with sync_reset=1 -> pc=0, level=0, no push. With PS_REL_JMP_EN: pc=0x20, jmp, jmp_rel, jmp_addr=0xE (-2) -> pc=0x1E.

Source files
------------

// File: rtl/program_sequencer_stack_if.sv
// Control/status bundle between the instruction decoder/ALU flags and the
// program sequencer. The decoder side uses the master modport; the sequencer
// uses the slave modport.
// Optional build macro: PS_REL_JMP_EN adds the jmp_rel control line.
interface program_sequencer_stack_if #(
  parameter int PM_ADDR_W   = 8,
  parameter int JMP_ADDR_W  = 4,
  parameter int STACK_DEPTH = 4
);
  localparam int LVL_W = $clog2(STACK_DEPTH + 1);

  logic                  jmp;
  logic                  jmp_nz;
  logic                  dont_jmp;
  logic                  call;
  logic                  ret;
  logic                  hold;
  logic [JMP_ADDR_W-1:0] jmp_addr;
`ifdef PS_REL_JMP_EN
  logic                  jmp_rel;
`endif
  logic [PM_ADDR_W-1:0]  pm_addr;
  logic [PM_ADDR_W-1:0]  pc;
  logic [LVL_W-1:0]      stack_level;
  logic                  stack_ovf;
  logic                  stack_unf;

`ifdef PS_REL_JMP_EN
  modport master (
    output jmp, jmp_nz, dont_jmp, call, ret, hold, jmp_addr, jmp_rel,
    input  pm_addr, pc, stack_level, stack_ovf, stack_unf
  );
  modport slave (
    input  jmp, jmp_nz, dont_jmp, call, ret, hold, jmp_addr, jmp_rel,
    output pm_addr, pc, stack_level, stack_ovf, stack_unf
  );
`else
  modport master (
    output jmp, jmp_nz, dont_jmp, call, ret, hold, jmp_addr,
    input  pm_addr, pc, stack_level, stack_ovf, stack_unf
  );
  modport slave (
    input  jmp, jmp_nz, dont_jmp, call, ret, hold, jmp_addr,
    output pm_addr, pc, stack_level, stack_ovf, stack_unf
  );
`endif
endinterface

// File: rtl/program_sequencer_stack.sv
// Program sequencer for the MPU341 core: computes the next program-memory
// address each cycle and registers it as pc. Supports sequential fetch,
// absolute jump, jump-on-not-zero, stall, and a call/return LIFO with sticky
// overflow/underflow flags.
// Optional build macro: PS_REL_JMP_EN enables pc-relative targets via jmp_rel.
module program_sequencer_stack #(
  parameter int PM_ADDR_W   = 8,
  parameter int JMP_ADDR_W  = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     sync_reset,
  program_sequencer_stack_if.slave bus
);
  localparam int LVL_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int SHIFT = PM_ADDR_W - JMP_ADDR_W;

  logic [PM_ADDR_W-1:0] pc_q;
  logic [LVL_W-1:0]     level_q;
  logic                 ovf_q;
  logic                 unf_q;
  // Sized to a power of two so any IDX_W-bit index is in range.
  logic [PM_ADDR_W-1:0] stack_mem [0:(1 << IDX_W)-1];

  logic [PM_ADDR_W-1:0] pc_inc;
  logic [PM_ADDR_W-1:0] abs_target;
  logic [PM_ADDR_W-1:0] target;
  logic [PM_ADDR_W-1:0] tos;
  logic [PM_ADDR_W-1:0] pm_addr_c;
  logic                 stack_empty;
  logic                 stack_full;
  logic                 do_push;
  logic                 do_pop;
  logic                 set_ovf;
  logic                 set_unf;

  assign pc_inc      = pc_q + PM_ADDR_W'(1);
  assign abs_target  = PM_ADDR_W'(bus.jmp_addr) << SHIFT;
  assign stack_empty = (level_q == '0);
  assign stack_full  = (level_q == LVL_W'(STACK_DEPTH));
  assign tos         = stack_mem[IDX_W'(level_q - LVL_W'(1))];

`ifdef PS_REL_JMP_EN
  assign target = bus.jmp_rel ? (pc_q + PM_ADDR_W'($signed(bus.jmp_addr)))
                              : abs_target;
`else
  assign target = abs_target;
`endif

  // Next-address priority selection and stack side effects for this edge.
  always_comb begin
    pm_addr_c = pc_inc;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;
    if (sync_reset) begin
      pm_addr_c = '0;
    end else if (bus.hold) begin
      pm_addr_c = pc_q;
    end else if (bus.ret) begin
      if (!stack_empty) begin
        pm_addr_c = tos;
        do_pop    = 1'b1;
      end else begin
        set_unf   = 1'b1;
      end
    end else if (bus.call) begin
      pm_addr_c = target;
      if (stack_full) set_ovf = 1'b1;
      else            do_push = 1'b1;
    end else if (bus.jmp) begin
      pm_addr_c = target;
    end else if (bus.jmp_nz && !bus.dont_jmp) begin
      pm_addr_c = target;
    end
  end

  // Program counter, stack level and sticky flags.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      pc_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q <= pm_addr_c;
      if (do_push)     level_q <= level_q + LVL_W'(1);
      else if (do_pop) level_q <= level_q - LVL_W'(1);
      if (set_ovf) ovf_q <= 1'b1;
      if (set_unf) unf_q <= 1'b1;
    end
  end

  // Return-address storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (do_push) stack_mem[IDX_W'(level_q)] <= pc_inc;
  end

  assign bus.pm_addr     = pm_addr_c;
  assign bus.pc          = pc_q;
  assign bus.stack_level = level_q;
  assign bus.stack_ovf   = ovf_q;
  assign bus.stack_unf   = unf_q;
endmodule

// File: tb/tb_program_sequencer_stack.sv
// Directed testbench for program_sequencer_stack (default parameters:
// PM_ADDR_W=8, JMP_ADDR_W=4, STACK_DEPTH=4). Expected values are hand-computed.
module tb_program_sequencer_stack;
  logic clk = 1'b0;
  logic sync_reset;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  program_sequencer_stack_if #(.PM_ADDR_W(8), .JMP_ADDR_W(4), .STACK_DEPTH(4)) bus ();

  program_sequencer_stack #(.PM_ADDR_W(8), .JMP_ADDR_W(4), .STACK_DEPTH(4)) dut (
    .clk        (clk),
    .sync_reset (sync_reset),
    .bus        (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_ctrl();
    bus.jmp = 1'b0; bus.jmp_nz = 1'b0; bus.dont_jmp = 1'b0;
    bus.call = 1'b0; bus.ret = 1'b0; bus.hold = 1'b0; bus.jmp_addr = '0;
`ifdef PS_REL_JMP_EN
    bus.jmp_rel = 1'b0;
`endif
  endtask

  // One clock edge, then settle away from the edge.
  task automatic tick(input int unsigned n = 1);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_call(input logic [3:0] a);
    idle_ctrl(); bus.call = 1'b1; bus.jmp_addr = a; tick(); idle_ctrl();
  endtask

  task automatic do_ret();
    idle_ctrl(); bus.ret = 1'b1; tick(); idle_ctrl();
  endtask

  task automatic do_jmp(input logic [3:0] a);
    idle_ctrl(); bus.jmp = 1'b1; bus.jmp_addr = a; tick(); idle_ctrl();
  endtask

  initial begin
    idle_ctrl();
    sync_reset = 1'b1;
    #1;
    check("pm_addr_in_reset", bus.pm_addr, 32'h0);
    tick();
    sync_reset = 1'b0;
    #1;
    check("rst_pc", bus.pc, 32'h0);
    check("rst_level", bus.stack_level, 32'h0);
    check("rst_ovf", bus.stack_ovf, 32'h0);
    check("rst_unf", bus.stack_unf, 32'h0);
    check("rst_pm_addr", bus.pm_addr, 32'h1);

    // Free-run and jumps
    tick(5);
    check("freerun_pc5", bus.pc, 32'h05);
    do_jmp(4'h3);
    check("jmp_30", bus.pc, 32'h30);
    tick();
    check("inc_31", bus.pc, 32'h31);
    bus.jmp_nz = 1'b1; bus.dont_jmp = 1'b1; bus.jmp_addr = 4'h7; tick(); idle_ctrl();
    check("jnz_not_taken", bus.pc, 32'h32);
    bus.jmp_nz = 1'b1; bus.dont_jmp = 1'b0; bus.jmp_addr = 4'hA; tick(); idle_ctrl();
    check("jnz_taken", bus.pc, 32'hA0);

    // Wrap-around
    do_jmp(4'hF);
    tick(15);
    check("pc_ff", bus.pc, 32'hFF);
    tick();
    check("wrap_00", bus.pc, 32'h00);

    // Single call/return
    do_jmp(4'h1);
    tick(2);
    check("pc_12", bus.pc, 32'h12);
    do_call(4'h4);
    check("call_pc", bus.pc, 32'h40);
    check("call_level", bus.stack_level, 32'h1);
    tick(3);
    do_ret();
    check("ret_pc", bus.pc, 32'h13);
    check("ret_level", bus.stack_level, 32'h0);

    // Nested calls, depth 3
    do_call(4'h5);            // push 0x14
    do_call(4'h6);            // push 0x51
    tick();                   // pc 0x61
    do_call(4'h7);            // push 0x62
    check("nest_pc", bus.pc, 32'h70);
    check("nest_level", bus.stack_level, 32'h3);
    do_ret();
    check("nest_ret1", bus.pc, 32'h62);
    do_ret();
    check("nest_ret2", bus.pc, 32'h51);
    do_ret();
    check("nest_ret3", bus.pc, 32'h14);
    check("nest_level0", bus.stack_level, 32'h0);

    // Overflow then underflow
    do_call(4'h1);            // push 0x15
    do_call(4'h2);            // push 0x11
    do_call(4'h3);            // push 0x21
    do_call(4'h4);            // push 0x31
    check("full_level", bus.stack_level, 32'h4);
    check("ovf_not_yet", bus.stack_ovf, 32'h0);
    do_call(4'h5);            // dropped push, jump still taken
    check("ovf_pc", bus.pc, 32'h50);
    check("ovf_level", bus.stack_level, 32'h4);
    check("ovf_flag", bus.stack_ovf, 32'h1);
    do_ret();
    check("ovf_ret1", bus.pc, 32'h31);
    do_ret();
    check("ovf_ret2", bus.pc, 32'h21);
    do_ret();
    check("ovf_ret3", bus.pc, 32'h11);
    do_ret();
    check("ovf_ret4", bus.pc, 32'h15);
    check("unf_not_yet", bus.stack_unf, 32'h0);
    do_ret();
    check("unf_pc", bus.pc, 32'h16);
    check("unf_flag", bus.stack_unf, 32'h1);
    check("unf_level", bus.stack_level, 32'h0);
    tick();
    check("ovf_sticky", bus.stack_ovf, 32'h1);
    check("unf_sticky", bus.stack_unf, 32'h1);

    // Hold overrides jmp
    bus.hold = 1'b1; bus.jmp = 1'b1; bus.jmp_addr = 4'h9;
    tick(3);
    check("hold_pc", bus.pc, 32'h17);
    check("hold_pm_addr", bus.pm_addr, 32'h17);
    check("hold_level", bus.stack_level, 32'h0);
    idle_ctrl();
    do_jmp(4'h9);
    check("after_hold_jmp", bus.pc, 32'h90);

    // call+ret together with one entry: pop only
    do_call(4'h2);            // push 0x91
    bus.call = 1'b1; bus.ret = 1'b1; bus.jmp_addr = 4'h3; tick(); idle_ctrl();
    check("callret_pc", bus.pc, 32'h91);
    check("callret_level", bus.stack_level, 32'h0);

    // jmp and jmp_nz together (dont_jmp set): jmp wins
    bus.jmp = 1'b1; bus.jmp_nz = 1'b1; bus.dont_jmp = 1'b1; bus.jmp_addr = 4'hC;
    tick(); idle_ctrl();
    check("jmp_over_jnz", bus.pc, 32'hC0);

    // Reset asserted during a call
    do_call(4'h4);            // level 1
    bus.call = 1'b1; bus.jmp_addr = 4'h5; sync_reset = 1'b1;
    #1;
    check("rst_call_pm_addr", bus.pm_addr, 32'h0);
    tick();
    sync_reset = 1'b0; idle_ctrl();
    #1;
    check("rst_call_pc", bus.pc, 32'h0);
    check("rst_call_level", bus.stack_level, 32'h0);
    check("rst_call_ovf", bus.stack_ovf, 32'h0);
    check("rst_call_unf", bus.stack_unf, 32'h0);
    do_ret();                 // empty stack proves no push under reset
    check("rst_call_ret_pc", bus.pc, 32'h1);
    check("rst_call_ret_unf", bus.stack_unf, 32'h1);

`ifdef PS_REL_JMP_EN
    do_jmp(4'h2);
    bus.jmp = 1'b1; bus.jmp_rel = 1'b1; bus.jmp_addr = 4'hE; tick(); idle_ctrl();
    check("rel_jmp_back", bus.pc, 32'h1E);
    bus.call = 1'b1; bus.jmp_rel = 1'b1; bus.jmp_addr = 4'h3; tick(); idle_ctrl();
    check("rel_call_pc", bus.pc, 32'h21);
    do_ret();
    check("rel_call_ret", bus.pc, 32'h1F);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
